// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared encodings and helpers for the data memory responder.
package data_mem_responder_pkg;
    localparam logic [1:0] dmem_idle  = 2'b00;
    localparam logic [1:0] dmem_load  = 2'b01;
    localparam logic [1:0] dmem_store = 2'b10;

    localparam logic [1:0] type_byte = 2'b00;
    localparam logic [1:0] type_half = 2'b01;
    localparam logic [1:0] type_word = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: execute-stage data-access bus between pipeline and responder.
interface data_mem_responder_if;
    logic [31:0] DATA_ADDRESS;
    logic [1:0]  DATA_CACHE_CONTROL;
    logic [1:0]  TYPE_IN;
    logic        LOAD_UNSIGNED;
    logic [31:0] STORE_DATA;
    logic        CACHE_READY;
    logic [31:0] DATA_OUT;
    logic        MISALIGNED;

    modport master (
        output DATA_ADDRESS, DATA_CACHE_CONTROL, TYPE_IN, LOAD_UNSIGNED, STORE_DATA,
        input  CACHE_READY, DATA_OUT, MISALIGNED
    );
    modport slave (
        input  DATA_ADDRESS, DATA_CACHE_CONTROL, TYPE_IN, LOAD_UNSIGNED, STORE_DATA,
        output CACHE_READY, DATA_OUT, MISALIGNED
    );
endinterface

// File: rtl/data_mem_responder_lane_unit.sv
// dmem_lane_unit: combinational byte-lane steering for stores, load extract/extend, misalignment detect.
module dmem_lane_unit
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  type_i,
    input  logic        unsigned_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o,
    output logic        misaligned_o
);
    logic        is_byte, is_half;
    logic [31:0] sh, byte_ext, half_ext;

    assign is_byte = type_i == type_byte;
    assign is_half = type_i == type_half;
    // reserved type 2'b11 behaves as a word access
    assign misaligned_o = is_half ? addr_lo_i[0] : (!is_byte && addr_lo_i != 2'b00);

    assign sh       = rdata_i >> {addr_lo_i, 3'b000};
    assign byte_ext = {{24{!unsigned_i && sh[7]}}, sh[7:0]};
    assign half_ext = {{16{!unsigned_i && sh[15]}}, sh[15:0]};

    always_comb begin
        be_o    = misaligned_o ? 4'b0000 :
                  is_byte      ? 4'b0001 << addr_lo_i :
                  is_half      ? (addr_lo_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_o = is_byte ? {4{store_data_i[7:0]}} :
                  is_half ? {2{store_data_i[15:0]}} : store_data_i;
        ldata_o = misaligned_o ? 32'd0 :
                  is_byte      ? byte_ext :
                  is_half      ? half_ext : rdata_i;
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: blocking load/store responder on a word-organised data memory.
// Optional DMEM_STATS_EN adds saturating LOAD/STORE/MISALIGN completion counters.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic CLK,
    input  logic RST,
    data_mem_responder_if.slave bus
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] LOAD_COUNT,
    output logic [31:0] STORE_COUNT,
    output logic [31:0] MISALIGN_COUNT
`endif
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    dmem_state_t     state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [1:0]      type_q, type_d;
    logic            uns_q, uns_d, store_q, store_d;
    logic [31:0]     data_q, data_d, dout_q, dout_d;
    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     rdata, wdata, ldata;
    logic [3:0]      be;
    logic            mis, accept, commit;
    logic            unused_addr;

    assign unused_addr = ^bus.DATA_ADDRESS[31:AW+2];
    assign rdata       = mem[addr_q[AW+1:2]];

    dmem_lane_unit u_lane (
        .addr_lo_i    (addr_q[1:0]),
        .type_i       (type_q),
        .unsigned_i   (uns_q),
        .store_data_i (data_q),
        .rdata_i      (rdata),
        .be_o         (be),
        .wdata_o      (wdata),
        .ldata_o      (ldata),
        .misaligned_o (mis)
    );

    assign accept = state_q != BUSY &&
                    (bus.DATA_CACHE_CONTROL == dmem_load || bus.DATA_CACHE_CONTROL == dmem_store);
    assign commit = state_q == BUSY && cnt_q == 4'd0;

    assign bus.CACHE_READY = state_q != BUSY;
    assign bus.MISALIGNED  = state_q == DONE && mis;
    assign bus.DATA_OUT    = dout_q;

    always_comb begin
        state_d = accept ? BUSY : commit ? DONE : state_q == BUSY ? BUSY : IDLE;
        cnt_d   = accept ? LAT_M1 : (state_q == BUSY && !commit) ? cnt_q - 4'd1 : cnt_q;
        addr_d  = accept ? bus.DATA_ADDRESS[AW+1:0] : addr_q;
        type_d  = accept ? bus.TYPE_IN : type_q;
        uns_d   = accept ? bus.LOAD_UNSIGNED : uns_q;
        data_d  = accept ? bus.STORE_DATA : data_q;
        store_d = accept ? bus.DATA_CACHE_CONTROL == dmem_store : store_q;
        dout_d  = (commit && !store_q) ? ldata : dout_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            type_q  <= '0;
            uns_q   <= 1'b0;
            data_q  <= '0;
            store_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            uns_q   <= uns_d;
            data_q  <= data_d;
            store_q <= store_d;
            dout_q  <= dout_d;
        end
    end

    // be is all-zero for misaligned accesses, so those never write
    always_ff @(posedge CLK) begin
        if (commit && store_q)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
    end

`ifdef DMEM_STATS_EN
    logic [31:0] ld_cnt_q, st_cnt_q, mis_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ld_cnt_q  <= '0;
            st_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else if (commit) begin
            if (mis) mis_cnt_q <= sat_inc(mis_cnt_q);
            else if (store_q) st_cnt_q <= sat_inc(st_cnt_q);
            else ld_cnt_q <= sat_inc(ld_cnt_q);
        end
    end

    assign LOAD_COUNT     = ld_cnt_q;
    assign STORE_COUNT    = st_cnt_q;
    assign MISALIGN_COUNT = mis_cnt_q;
`endif
endmodule
